// File: rtl/regfile_dump.sv
`default_nettype none
// ============================================================================
// Module   : regfile_dump
// Brief    : Streams the contents of a register file out over a valid/ready
//            port, one word per two cycles at best, with a running checksum.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_dump #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [4:0]        reg_raddr,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic [4:0]        dump_idx,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [4:0] c_lastIdx = 5'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [4:0]          r_count;
  logic                r_valid;
  logic                r_done;
  logic [DATA_W-1:0]   r_data;
  logic [DATA_W-1:0]   r_checksum;
  logic [4:0]          r_idx;
  logic                w_start;
  logic                w_capture;
  logic                w_accept;
  logic                w_cancel;

  // State register; reset drops straight back to IDLE regardless of clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode plus one-cycle strobes that steer the datapath.
  always_comb begin
    w_nextState = r_state;
    w_start     = 1'b0;
    w_capture   = 1'b0;
    w_accept    = 1'b0;
    w_cancel    = 1'b0;
    case (r_state)
      IDLE: begin
        // abort is meaningless here, so start alone decides.
        if (start) begin
          w_nextState = READ;
          w_start     = 1'b1;
        end
      end
      READ: begin
        if (abort) begin
          w_nextState = IDLE;
          w_cancel    = 1'b1;
        end else begin
          w_nextState = SEND;
          w_capture   = 1'b1;
        end
      end
      SEND: begin
        // abort wins over a same-cycle handshake; that word is dropped.
        if (abort) begin
          w_nextState = IDLE;
          w_cancel    = 1'b1;
        end else if (r_valid && dump_ready) begin
          w_accept    = 1'b1;
          w_nextState = (r_count == c_lastIdx) ? DONE : READ;
        end
      end
      DONE: begin
        w_nextState = IDLE;
        w_cancel    = abort;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Datapath: counter, captured word, handshake flag, checksum and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count    <= 5'd0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
      r_data     <= '0;
      r_idx      <= 5'd0;
      r_checksum <= '0;
    end else begin
      // done is registered off the DONE state, so it lands as IDLE resumes.
      r_done <= (r_state == DONE) && !w_cancel;
      if (w_start) begin
        r_count    <= 5'd0;
        r_checksum <= '0;
      end
      if (w_capture) begin
        r_data  <= reg_rdata;
        r_idx   <= r_count;
        r_valid <= 1'b1;
      end
      if (w_accept) begin
        r_checksum <= r_checksum + r_data;
        r_valid    <= 1'b0;
        if (r_count != c_lastIdx) begin
          r_count <= r_count + 5'd1;
        end
      end
      if (w_cancel) begin
        r_valid <= 1'b0;
      end
    end
  end

  // Read address follows the counter only while a word is being fetched/sent.
  always_comb begin
    reg_raddr = 5'd0;
    if (r_state == READ || r_state == SEND) begin
      reg_raddr = r_count;
    end
  end

  assign busy       = (r_state != IDLE);
  assign done       = r_done;
  assign dump_valid = r_valid;
  assign dump_data  = r_data;
  assign dump_idx   = r_idx;
  assign checksum   = r_checksum;

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_dump
// Brief    : Self-checking bench for regfile_dump (32-word and 4-word builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_dump;

  localparam int N  = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic          dumpReady;
  logic [4:0]    raddr;
  logic [DW-1:0] rdata;
  logic          dumpValid;
  logic [DW-1:0] dumpData;
  logic [4:0]    dumpIdx;
  logic          busy;
  logic          done;
  logic [DW-1:0] checksum;

  logic          start4;
  logic          abort4;
  logic          ready4;
  logic [4:0]    raddr4;
  logic [DW-1:0] rdata4;
  logic          valid4;
  logic [DW-1:0] data4;
  logic [4:0]    idx4;
  logic          busy4;
  logic          done4;
  logic [DW-1:0] checksum4;

  logic [DW-1:0] regs [0:31];

  int checks = 0;
  int errors = 0;
  int capIdx[$];
  logic [DW-1:0] capData[$];

  assign rdata  = regs[raddr];
  assign rdata4 = regs[raddr4];

  always #5 clk = ~clk;

  regfile_dump #(.NUM_REGS(N), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .reg_raddr(raddr), .reg_rdata(rdata),
    .dump_valid(dumpValid), .dump_ready(dumpReady),
    .dump_data(dumpData), .dump_idx(dumpIdx),
    .busy(busy), .done(done), .checksum(checksum)
  );

  regfile_dump #(.NUM_REGS(4), .DATA_W(DW)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .abort(abort4),
    .reg_raddr(raddr4), .reg_rdata(rdata4),
    .dump_valid(valid4), .dump_ready(ready4),
    .dump_data(data4), .dump_idx(idx4),
    .busy(busy4), .done(done4), .checksum(checksum4)
  );

  // Drives one dump on the 32-word instance and records what the consumer saw.
  // stallMode >= 0 : hold ready low that many cycles per word; < 0 : random 0..3.
  task automatic drive_dump(input int stallMode, input int abortIdx, input bit spamStart,
                            output int cyclesToDone, output int donePulses,
                            output int protoErrs, output int totalStall, output bit timedOut);
    int edges;
    int stallLeft;
    int tail;
    bit prevValid;
    logic [DW-1:0] holdData;
    logic [4:0] holdIdx;
    capIdx.delete();
    capData.delete();
    cyclesToDone = -1; donePulses = 0; protoErrs = 0; totalStall = 0; timedOut = 0;
    stallLeft = 0; tail = 0; prevValid = 0; holdData = '0; holdIdx = '0;
    dumpReady = 1'b1; abort = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    edges = 1;
    start = 1'b0;
    while (tail < 4) begin
      if (edges > 2000) begin
        timedOut = 1;
        break;
      end
      abort = 1'b0;
      start = (spamStart && busy) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (done) begin
        donePulses++;
        if (cyclesToDone < 0) cyclesToDone = edges;
      end
      if (dumpValid) begin
        if (!prevValid) begin
          holdData  = dumpData;
          holdIdx   = dumpIdx;
          stallLeft = (stallMode < 0) ? int'($urandom_range(0, 3)) : stallMode;
          totalStall += stallLeft;
        end else if (dumpData !== holdData || dumpIdx !== holdIdx) begin
          protoErrs++;
        end
        if (raddr !== dumpIdx) protoErrs++;
        if (stallLeft > 0) begin
          dumpReady = 1'b0;
          stallLeft--;
        end else begin
          dumpReady = 1'b1;
          if (int'(dumpIdx) == abortIdx) begin
            abort = 1'b1;
          end else begin
            capIdx.push_back(int'(dumpIdx));
            capData.push_back(dumpData);
          end
        end
      end else begin
        dumpReady = 1'($urandom_range(0, 1));
      end
      if (!busy) tail++;
      prevValid = dumpValid;
      @(posedge clk); #1;
      edges++;
    end
    abort = 1'b0;
    start = 1'b0;
    dumpReady = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; abort = 0; dumpReady = 0;
    start4 = 0; abort4 = 0; ready4 = 1;
    #2;
    checks++;
    if ({busy, done, dumpValid, raddr, dumpIdx, dumpData, checksum} !== '0) begin
      errors++;
      $display("FAIL reset_async_outputs: got busy=%b done=%b valid=%b raddr=%0d idx=%0d data=%0h sum=%0h, want all zero",
               busy, done, dumpValid, raddr, dumpIdx, dumpData, checksum);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, dumpValid, raddr, dumpIdx, dumpData, checksum} !== '0) begin
      errors++;
      $display("FAIL reset_release_idle: got busy=%b valid=%b sum=%0h, want all zero", busy, dumpValid, checksum);
    end
  endtask

  task automatic test_full_dump();
    int cyc, dp, pe, ts;
    bit to;
    for (int i = 0; i < 32; i++) regs[i] = DW'(i);
    drive_dump(0, -1, 0, cyc, dp, pe, ts, to);
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL full_timeout: got %0d want 0", to); end
    checks++;
    if (capIdx.size() !== N) begin errors++; $display("FAIL full_count: got %0d want %0d", capIdx.size(), N); end
    for (int i = 0; i < capIdx.size(); i++) begin
      checks++;
      if (capIdx[i] !== i || capData[i] !== DW'(i)) begin
        errors++;
        $display("FAIL full_word%0d: got idx=%0d data=%0d want %0d", i, capIdx[i], capData[i], i);
      end
    end
    checks++;
    if (cyc !== 66) begin errors++; $display("FAIL full_latency: got %0d want 66", cyc); end
    checks++;
    if (dp !== 1) begin errors++; $display("FAIL full_done_pulses: got %0d want 1", dp); end
    checks++;
    if (checksum !== 496) begin errors++; $display("FAIL full_checksum: got %0d want 496", checksum); end
    checks++;
    if (pe !== 0) begin errors++; $display("FAIL full_protocol: got %0d errors want 0", pe); end
  endtask

  task automatic test_idle_hold();
    abort = 1'b1;
    for (int k = 0; k < 5; k++) begin
      dumpReady = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    abort = 1'b0;
    dumpReady = 1'b1;
    checks++;
    if (checksum !== 496) begin errors++; $display("FAIL idle_checksum_hold: got %0d want 496", checksum); end
    checks++;
    if ({busy, dumpValid, done} !== 3'b000) begin
      errors++;
      $display("FAIL idle_abort_noeffect: got busy=%b valid=%b done=%b want 000", busy, dumpValid, done);
    end
  endtask

  task automatic test_stall();
    int cyc, dp, pe, ts;
    bit to;
    for (int i = 0; i < 32; i++) regs[i] = DW'(i);
    drive_dump(3, -1, 0, cyc, dp, pe, ts, to);
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL stall_timeout: got %0d want 0", to); end
    checks++;
    if (capIdx.size() !== N) begin errors++; $display("FAIL stall_count: got %0d want %0d", capIdx.size(), N); end
    for (int i = 0; i < capIdx.size(); i++) begin
      checks++;
      if (capIdx[i] !== i || capData[i] !== DW'(i)) begin
        errors++;
        $display("FAIL stall_word%0d: got idx=%0d data=%0d want %0d", i, capIdx[i], capData[i], i);
      end
    end
    checks++;
    if (cyc !== 162) begin errors++; $display("FAIL stall_latency: got %0d want 162", cyc); end
    checks++;
    if (checksum !== 496) begin errors++; $display("FAIL stall_checksum: got %0d want 496", checksum); end
    checks++;
    if (pe !== 0) begin errors++; $display("FAIL stall_stability: got %0d errors want 0", pe); end
  endtask

  task automatic test_abort();
    int cyc, dp, pe, ts;
    bit to;
    for (int i = 0; i < 32; i++) regs[i] = DW'(i);
    drive_dump(0, 5, 0, cyc, dp, pe, ts, to);
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL abort_timeout: got %0d want 0", to); end
    checks++;
    if (capIdx.size() !== 5) begin errors++; $display("FAIL abort_words: got %0d want 5", capIdx.size()); end
    checks++;
    if (dp !== 0) begin errors++; $display("FAIL abort_no_done: got %0d want 0", dp); end
    checks++;
    if (checksum !== 10) begin errors++; $display("FAIL abort_checksum: got %0d want 10", checksum); end
    checks++;
    if ({busy, dumpValid} !== 2'b00) begin
      errors++;
      $display("FAIL abort_idle: got busy=%b valid=%b want 00", busy, dumpValid);
    end
  endtask

  task automatic test_start_abort_idle();
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL start_with_abort: got busy=%b want 1", busy); end
    checks++;
    if (checksum !== 0) begin errors++; $display("FAIL start_clears_sum: got %0d want 0", checksum); end
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if ({busy, dumpValid} !== 2'b00) begin
      errors++;
      $display("FAIL abort_in_read: got busy=%b valid=%b want 00", busy, dumpValid);
    end
  endtask

  task automatic test_async_reset();
    int cyc, dp, pe, ts;
    bit to;
    bit seen;
    for (int i = 0; i < 32; i++) regs[i] = DW'(i);
    dumpReady = 1'b1; abort = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      if (dumpValid && dumpIdx == 5'd12) seen = 1;
      else begin @(posedge clk); #1; end
    end
    checks++;
    if (seen !== 1'b1) begin errors++; $display("FAIL areset_reach_word12: got %0d want 1", seen); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, dumpValid, raddr, dumpIdx, dumpData, checksum} !== '0) begin
      errors++;
      $display("FAIL areset_midcycle: got busy=%b valid=%b idx=%0d data=%0d sum=%0d want all zero",
               busy, dumpValid, dumpIdx, dumpData, checksum);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if ({busy, dumpValid} !== 2'b00) begin errors++; $display("FAIL areset_waits_idle: got busy=%b valid=%b want 00", busy, dumpValid); end
    drive_dump(0, -1, 0, cyc, dp, pe, ts, to);
    checks++;
    if (capIdx.size() !== N || checksum !== 496 || to !== 1'b0) begin
      errors++;
      $display("FAIL areset_redump: got words=%0d sum=%0d timeout=%0d want 32/496/0", capIdx.size(), checksum, to);
    end
  endtask

  task automatic test_start_spam();
    int cyc, dp, pe, ts;
    bit to;
    for (int i = 0; i < 32; i++) regs[i] = DW'(i);
    drive_dump(0, -1, 1, cyc, dp, pe, ts, to);
    checks++;
    if (capIdx.size() !== N || to !== 1'b0) begin
      errors++;
      $display("FAIL spam_words: got %0d timeout=%0d want %0d/0", capIdx.size(), to, N);
    end
    checks++;
    if (dp !== 1) begin errors++; $display("FAIL spam_done_pulses: got %0d want 1", dp); end
    checks++;
    if (checksum !== 496 || cyc !== 66) begin
      errors++;
      $display("FAIL spam_sum_latency: got sum=%0d cyc=%0d want 496/66", checksum, cyc);
    end
  endtask

  task automatic test_random();
    int cyc, dp, pe, ts;
    bit to;
    logic [DW-1:0] expSum;
    for (int it = 0; it < 3; it++) begin
      expSum = '0;
      for (int i = 0; i < 32; i++) begin
        regs[i] = DW'($urandom);
        expSum = expSum + regs[i];
      end
      drive_dump(-1, -1, 0, cyc, dp, pe, ts, to);
      checks++;
      if (capIdx.size() !== N || to !== 1'b0) begin
        errors++;
        $display("FAIL rand%0d_words: got %0d timeout=%0d want %0d/0", it, capIdx.size(), to, N);
      end
      for (int i = 0; i < capIdx.size(); i++) begin
        checks++;
        if (capIdx[i] !== i || capData[i] !== regs[i]) begin
          errors++;
          $display("FAIL rand%0d_word%0d: got idx=%0d data=%0h want idx=%0d data=%0h", it, i, capIdx[i], capData[i], i, regs[i]);
        end
      end
      checks++;
      if (checksum !== expSum) begin errors++; $display("FAIL rand%0d_checksum: got %0h want %0h", it, checksum, expSum); end
      checks++;
      if (cyc !== 2 * N + ts + 2) begin errors++; $display("FAIL rand%0d_latency: got %0d want %0d", it, cyc, 2 * N + ts + 2); end
      checks++;
      if (pe !== 0 || dp !== 1) begin errors++; $display("FAIL rand%0d_protocol: got errs=%0d done=%0d want 0/1", it, pe, dp); end
    end
  endtask

  task automatic test_small();
    int words, dp, cyc, edges;
    logic [DW-1:0] sum;
    for (int i = 0; i < 32; i++) regs[i] = DW'(i);
    words = 0; dp = 0; cyc = -1; sum = '0;
    ready4 = 1'b1; abort4 = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    edges = 1;
    while (edges < 40) begin
      start4 = 1'($urandom_range(0, 1));
      if (done4) begin
        dp++;
        if (cyc < 0) cyc = edges;
      end
      if (!busy4) start4 = 1'b0;
      if (valid4) begin
        if (int'(idx4) !== words || data4 !== DW'(words)) begin
          checks++;
          errors++;
          $display("FAIL small_word%0d: got idx=%0d data=%0d", words, idx4, data4);
        end
        sum = sum + data4;
        words++;
      end
      @(posedge clk); #1;
      edges++;
    end
    start4 = 1'b0;
    checks++;
    if (words !== 4) begin errors++; $display("FAIL small_words: got %0d want 4", words); end
    checks++;
    if (checksum4 !== 6 || sum !== 6) begin errors++; $display("FAIL small_checksum: got %0d want 6", checksum4); end
    checks++;
    if (dp !== 1 || cyc !== 10) begin errors++; $display("FAIL small_done: got pulses=%0d cyc=%0d want 1/10", dp, cyc); end
  endtask

  initial begin
    test_reset();
    test_full_dump();
    test_idle_hold();
    test_stall();
    test_abort();
    test_start_abort_idle();
    test_async_reset();
    test_start_spam();
    test_random();
    test_small();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
